mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port unified memory between the core's instruction-fetch requester and its load/store requester. Sits between the fetch/data stages of the single-cycle core and the memory macro. A three-state FSM serializes accesses, gives data accesses priority, bounds fetch starvation and registers responses back to the owner. The core stalls on the absence of `rvalid`.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive data grants tolerated while fetch is pending (≥1)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_req`  in  1  fetch request, held until `i_gnt`
- `i_addr`  in  ADDR_W  fetch address
- `i_gnt`  out  1  fetch request accepted (1-cycle pulse)
- `i_rvalid`  out  1  fetch data valid (1-cycle pulse)
- `i_rdata`  out  DATA_W  fetch data
- `d_req`  in  1  data request, held until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data request accepted (1-cycle pulse)
- `d_rvalid`  out  1  load data valid, or store complete (1-cycle pulse)
- `d_rdata`  out  DATA_W  load data (0 for stores)
- `mem_req`  out  1  memory request
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_ready`  in  1  memory accepts `mem_req` this cycle
- `mem_rvalid`  in  1  memory read data valid
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any request is pending, select a winner and capture its addr, we and wdata into registers. For fetch, capture we=0.
  - Pulse the winner's `gnt` combinationally in this cycle. Go to ISSUE.
  - If no request is pending, stay in IDLE.
- **Winner selection**
  - Only one requester pending: that requester wins.
  - Both pending: data wins, unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- **Starvation counter (`starve_cnt`)**
  - Increments on a data grant made while `i_req=1`.
  - Clears on any fetch grant.
  - Saturates at STARVE_LIMIT.
- **ISSUE**
  - Drive `mem_req=1` with the captured fields. Hold them stable until `mem_ready`.
  - On `mem_ready`: a write goes to IDLE and sets the owner's response registers. A read goes to WAIT.
- **WAIT**
  - On `mem_rvalid`, register `mem_rdata` into the owner's `rdata`, set the owner's `rvalid`, and go to IDLE.
  - `mem_rvalid` outside WAIT is ignored.
- **Response outputs**
  - `rvalid` is registered and high for exactly one cycle.
  - `rdata` holds its value until the next response to the same owner.
- **Memory outputs**
  - `mem_we`, `mem_addr` and `mem_wdata` are 0 whenever `mem_req=0`.
- At most one access is outstanding at any time. No new grant is issued while `busy=1`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `starve_cnt` 0, captured registers 0.
- Reset asserted mid-access: the transaction is abandoned and no `rvalid` is produced. The memory is reset by the same `rst_n`.
- `gnt` is asserted in the same cycle as `req` when in IDLE (cycle 0).
- `mem_req` rises in cycle 1.
- Read, `mem_ready` at cycle k and `mem_rvalid` at cycle m>k: `rvalid` at m+1. Minimum grant-to-`rvalid` is 3 cycles.
- Write, `mem_ready` at cycle k: `d_rvalid` at k+1. Minimum grant-to-`rvalid` is 2 cycles.
- Back-to-back: the next grant can occur in the cycle the FSM re-enters IDLE. This is the same cycle `rvalid` is asserted.
- Request withdrawn before `gnt`: not allowed. A bench assertion flags `req` falling without `gnt`.

## Configuration
- Macro `MEM_ARB_PERF_EN`.
- Defined: adds three 32-bit output ports, all wrapping, all reset to 0:
  - `perf_i_grants`: counts `i_gnt` pulses
  - `perf_d_grants`: counts `d_gnt` pulses
  - `perf_stall_cycles`: counts cycles with (`i_req & ~i_gnt`) | (`d_req & ~d_gnt`)
- Undefined: these ports and registers are absent. Behaviour is otherwise identical.

## Structure
- Shared package `riscv_pkg`:
  - State enum `arb_state_t` {IDLE, ISSUE, WAIT}
  - Owner encoding `OWNER_I=1'b0`, `OWNER_D=1'b1`
  - Default widths
- Sub-module `mem_arb_pick`: combinational winner selection.
  - Inputs: `i_req`, `d_req`, `starve_cnt`.
  - Output: `owner`, `any_req`.
  - The FSM, capture registers and counters stay in `mem_arbiter`.

## Test plan
- Single fetch, `i_addr=0x10`, memory returns `0xDEADBEEF` with `mem_ready` at cycle 1 and `mem_rvalid` at cycle 2: `i_gnt` at cycle 0, `i_rvalid` at cycle 3 with `i_rdata=0xDEADBEEF`.
- Store `d_addr=0x40`, `d_wdata=0x1234` with `mem_ready` delayed 3 cycles: `mem_we=1` and the fields are held stable through the wait, `d_rvalid` follows one cycle after `mem_ready`, `d_rdata=0`.
- `i_req` and `d_req` asserted together in cycle 0: `d_gnt` is granted first, and `i_gnt` is granted in the cycle the data access completes.
- `i_req` held high while `d_req` is continuously re-asserted: fetch is granted after exactly 4 data grants (STARVE_LIMIT=4), then `starve_cnt` returns to 0.
- `rst_n` pulsed low while in WAIT: all outputs go to 0 immediately, no `rvalid` fires, and the next request is granted normally from IDLE.
- With `MEM_ARB_PERF_EN` defined, 5 fetches and 3 stores: `perf_i_grants=5`, `perf_d_grants=3`, and `perf_stall_cycles` equals the waiting-request cycle count from the reference model.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the memory arbiter slice.
// Optional perf counters in mem_arbiter are enabled by MEM_ARB_PERF_EN.
package riscv_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_DEF = 4;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// Data wins ties unless fetch has been starved for STARVE_LIMIT grants.
module mem_arb_pick
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_DEF,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             owner,
  output logic             any_req
);

  logic starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign any_req = i_req | d_req;

  always_comb begin
    owner = OWNER_I;
    unique case (1'b1)
      d_req & ~(i_req & starved): owner = OWNER_D;
      default:                    owner = OWNER_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch vs load/store, IDLE/ISSUE/WAIT FSM.
// Define MEM_ARB_PERF_EN to add grant and stall performance counters.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_stall_cycles,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state;
  arb_state_t        state_nx;
  logic              owner;
  logic              any_req;
  logic              grant;
  logic              cap_owner;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [CNT_W-1:0]  starve_cnt;
  logic              done_wr;
  logic              done_rd;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
    .starve_cnt(starve_cnt),
    .owner     (owner),
    .any_req   (any_req)
  );

  // Grants are suppressed while reset is held so every output reads 0.
  assign grant = (state == IDLE) & any_req & rst_n;
  assign i_gnt = grant & (owner == OWNER_I);
  assign d_gnt = grant & (owner == OWNER_D);
  assign busy  = (state != IDLE);

  assign mem_req   = (state == ISSUE);
  assign mem_we    = mem_req & cap_we;
  assign mem_addr  = mem_req ? cap_addr : '0;
  assign mem_wdata = mem_req ? cap_wdata : '0;

  assign done_wr = (state == ISSUE) & mem_ready & cap_we;
  assign done_rd = (state == WAIT) & mem_rvalid;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = ISSUE;
      ISSUE:   if (mem_ready) state_nx = cap_we ? IDLE : WAIT;
      WAIT:    if (mem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_owner <= OWNER_I;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (grant) begin
      cap_owner <= owner;
      cap_we    <= (owner == OWNER_D) & d_we;
      cap_addr  <= (owner == OWNER_D) ? d_addr : i_addr;
      cap_wdata <= (owner == OWNER_D) ? d_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (i_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt & i_req &
                 (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Stores report completion with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (done_wr | done_rd) begin
        if (cap_owner == OWNER_D) begin
          d_rvalid <= 1'b1;
          d_rdata  <= done_rd ? mem_rdata : '0;
        end else begin
          i_rvalid <= 1'b1;
          i_rdata  <= done_rd ? mem_rdata : '0;
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic stall;

  assign stall = (i_req & ~i_gnt) | (d_req & ~d_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants     <= '0;
      perf_d_grants     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_i_grants     <= perf_i_grants + {31'b0, i_gnt};
      perf_d_grants     <= perf_d_grants + {31'b0, d_gnt};
      perf_stall_cycles <= perf_stall_cycles + {31'b0, stall};
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions
// plus hand sequences for priority, starvation, reset and perf counters.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_grants;
  logic [31:0] perf_d_grants;
  logic [31:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req            (i_req),
    .i_addr           (i_addr),
    .i_gnt            (i_gnt),
    .i_rvalid         (i_rvalid),
    .i_rdata          (i_rdata),
    .d_req            (d_req),
    .d_we             (d_we),
    .d_addr           (d_addr),
    .d_wdata          (d_wdata),
    .d_gnt            (d_gnt),
    .d_rvalid         (d_rvalid),
    .d_rdata          (d_rdata),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ready        (mem_ready),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
`ifdef MEM_ARB_PERF_EN
    .perf_i_grants    (perf_i_grants),
    .perf_d_grants    (perf_d_grants),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .busy             (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  typedef struct {
    logic        own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdly;
    int          vdly;
    logic        spur;
    logic [31:0] mdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " ctl"},
        {i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_req, mem_we,
         mem_addr, mem_wdata}, '0);
    chk({nm, " rdata"}, {i_rdata, d_rdata}, '0);
  endtask

  task automatic clr_inputs();
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Requests must not be withdrawn before their grant.
  logic i_pend = 1'b0;
  logic d_pend = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      i_pend <= 1'b0;
      d_pend <= 1'b0;
    end else begin
      if (i_pend && !i_req) begin
        errors++;
        $display("FAIL req_withdraw: i_req=0 required 1 until i_gnt");
      end
      if (d_pend && !d_req) begin
        errors++;
        $display("FAIL req_withdraw: d_req=0 required 1 until d_gnt");
      end
      i_pend <= i_req & ~i_gnt;
      d_pend <= d_req & ~d_gnt;
    end
  end

  task automatic do_xfer(input vec_t v, input string nm);
    int lat;
    int ready_c;
    int rv_c;
    lat = -1;
    ready_c = 1 + v.rdly;
    rv_c = ready_c + 1 + v.vdly;
    @(negedge clk);
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 32'hBAD0_0000;
    if (v.own) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1; i_addr = v.addr;
    end
    #1;
    chk({nm, " gnt"}, {i_gnt, d_gnt}, v.own ? 2'b01 : 2'b10);
    for (int c = 1; c <= 30 && lat < 0; c++) begin
      @(negedge clk);
      i_req = 0; i_addr = 32'h5A5A_5A5A;
      d_req = 0; d_we = 0; d_addr = 32'h5A5A_5A5A; d_wdata = 32'h77;
      mem_ready = (c == ready_c);
      mem_rvalid = (!v.we && c == rv_c) || (v.spur && c < ready_c);
      mem_rdata = (!v.we && c == rv_c) ? v.mdata : (32'hBAD0_0000 | c);
      #1;
      if (c <= ready_c)
        chk($sformatf("%s issue c%0d", nm, c),
            {mem_req, mem_we, mem_addr, v.we ? mem_wdata : 32'h0},
            {1'b1, v.we, v.addr, v.we ? v.wdata : 32'h0});
      else
        chk($sformatf("%s memidle c%0d", nm, c),
            {mem_req, mem_we, mem_addr, mem_wdata}, '0);
      if (i_rvalid | d_rvalid) lat = c;
    end
    if (lat < 0) lat = 99;
    chk({nm, " latency"}, lat, v.exp_lat);
    if (v.own) exp_d_rdata = v.exp_rdata;
    else exp_i_rdata = v.exp_rdata;
    chk({nm, " rsp"}, {i_rvalid, d_rvalid, i_rdata, d_rdata},
        {~v.own, v.own, exp_i_rdata, exp_d_rdata});
    @(negedge clk);
    clr_inputs();
    #1;
    chk({nm, " after"}, {i_rvalid, d_rvalid, busy, i_rdata, d_rdata},
        {3'b000, exp_i_rdata, exp_d_rdata});
  endtask

  // Both requesters in cycle 0: store first, fetch granted as it completes.
  task automatic seq_both();
    @(negedge clk);
    i_req = 1; i_addr = 32'h20;
    d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'h55;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 32'hBAD1;
    #1;
    chk("both c0 gnt", {i_gnt, d_gnt}, 2'b01);
    @(negedge clk);
    d_req = 0; d_we = 0; mem_ready = 1;
    #1;
    chk("both c1", {i_gnt, busy, mem_req, mem_we, mem_addr, mem_wdata},
        {4'b0111, 32'h44, 32'h55});
    @(negedge clk);
    mem_ready = 0;
    #1;
    chk("both c2", {d_rvalid, i_gnt, d_gnt, d_rdata}, {3'b110, 32'h0});
    @(negedge clk);
    i_req = 0; i_addr = '0; mem_ready = 1;
    #1;
    chk("both c3", {mem_req, mem_we, mem_addr}, {2'b10, 32'h20});
    @(negedge clk);
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = 32'hBAD2;
    #1;
    exp_i_rdata = 32'h77;
    exp_d_rdata = 32'h0;
    chk("both c5", {i_rvalid, d_rvalid, i_rdata, d_rdata},
        {2'b10, exp_i_rdata, exp_d_rdata});
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic seq_starve();
    logic [9:0] exp_pat;
    int n;
    bit got;
    exp_pat = 10'b10000_10000;
    n = 0;
    got = 0;
    @(negedge clk);
    i_req = 1; i_addr = 32'h100;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h300;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h99;
    for (int c = 0; c < 60 && n < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (i_gnt | d_gnt) begin
        chk($sformatf("starve grant %0d", n), {i_gnt, d_gnt},
            exp_pat[n] ? 2'b10 : 2'b01);
        n++;
      end
    end
    chk("starve grant count", n, 10);
    @(negedge clk);
    i_req = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      #1;
      got = d_gnt;
    end
    chk("starve drain gnt", got, 1'b1);
    @(negedge clk);
    d_req = 0; d_we = 0;
    repeat (3) @(negedge clk);
    clr_inputs();
    #1;
    exp_i_rdata = 32'h99;
    exp_d_rdata = 32'h0;
    chk("starve drain", {busy, i_rdata, d_rdata},
        {1'b0, exp_i_rdata, exp_d_rdata});
  endtask

  task automatic seq_reset();
    @(negedge clk);
    i_req = 1; i_addr = 32'h30; mem_ready = 0;
    #1;
    chk("rst gnt", {i_gnt, d_gnt}, 2'b10);
    @(negedge clk);
    i_req = 0; i_addr = '0; mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    #1;
    chk("rst in wait", {busy, mem_req}, 2'b10);
    #1;
    rst_n = 0;
    #1;
    check_zero("rst mid");
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h66;
    @(negedge clk);
    rst_n = 1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst quiet %0d", c),
          {i_rvalid, d_rvalid, busy, i_rdata, d_rdata}, '0);
    end
    clr_inputs();
    do_xfer(tbl[0], "post_rst");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clr_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // own, we, addr, wdata, rdly, vdly, spur, mdata, lat, rdata
    tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 0, 0, 1'b0,
               32'hDEADBEEF, 3, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h40, 32'h1234, 3, 0, 1'b1,
               32'h0, 5, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h80, 32'h0, 1, 2, 1'b0,
               32'hCAFEF00D, 6, 32'hCAFEF00D};
    tbl[3] = '{1'b0, 1'b0, 32'h14, 32'h0, 2, 0, 1'b1,
               32'h00000013, 5, 32'h00000013};
    tbl[4] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 0, 3, 1'b0,
               32'h12345678, 6, 32'h12345678};
    tbl[5] = '{1'b1, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 0, 0, 1'b0,
               32'h0, 2, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0,
               32'hA5A5A5A5, 3, 32'hA5A5A5A5};

    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 7; i++)
      do_xfer(tbl[i], $sformatf("vec%0d", i));

    seq_starve();
    seq_both();
    seq_reset();

`ifdef MEM_ARB_PERF_EN
    pulse_reset();
    #1;
    chk("perf reset", {perf_i_grants, perf_d_grants, perf_stall_cycles}, '0);
    seq_both();
    do_xfer(tbl[0], "perf_f1");
    do_xfer(tbl[3], "perf_f2");
    do_xfer(tbl[4], "perf_f3");
    do_xfer(tbl[0], "perf_f4");
    do_xfer(tbl[1], "perf_s1");
    do_xfer(tbl[5], "perf_s2");
    chk("perf_i_grants", perf_i_grants, 32'd5);
    chk("perf_d_grants", perf_d_grants, 32'd3);
    chk("perf_stall_cycles", perf_stall_cycles, 32'd2);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
